mcu_gpio_sw_responder: RTL and testbench

- Fabric-side responder for a single-wire, half-duplex register-access protocol that the Cortex-M3 bit-bangs on GPIO_H0.
- Decodes the MCU's GPIO output and output-enable pair into frames. Issues register writes and reads to fabric logic.
- Returns read data to the MCU by pulling the shared line low on the MCU's GPIO input.
- Sits between the hard MCU instance and fabric peripheral registers.

---
 rtl/mcu_gpio_sw_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_mcu_gpio_sw_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_gpio_sw_responder.sv
// Fabric responder for the MCU's bit-banged single-wire register protocol on GPIO_H0.
// Optional presence pulse after a frame reset: define SWR_PRESENCE_EN.
module mcu_gpio_sw_responder #(
   parameter int unsigned RST_CYC  = 480,
   parameter int unsigned BIT_THR  = 60,
   parameter int unsigned HOLD_CYC = 90,
   parameter int unsigned CNT_W    = 16
) (
   input  logic       ppm_clk,
   input  logic       rst,
   input  logic       mcu_out,
   input  logic       mcu_oe_n,
   output logic       mcu_in,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       rd_req,
   output logic [6:0] rd_addr,
   input  logic [7:0] rd_data
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CMD   = 3'd1;
   localparam logic [2:0] ST_WDATA = 3'd2;
   localparam logic [2:0] ST_RLOAD = 3'd3;
   localparam logic [2:0] ST_RDATA = 3'd4;
`ifdef SWR_PRESENCE_EN
   localparam logic [2:0] ST_PRES  = 3'd5;
   localparam logic [CNT_W-1:0] PRES_ON  = CNT_W'(14);
   localparam logic [CNT_W-1:0] PRES_END = CNT_W'(134);
`endif

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] RST_LIM  = CNT_W'(RST_CYC);
   localparam logic [CNT_W-1:0] BIT_LIM  = CNT_W'(BIT_THR);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYC);

   logic             mcu_low;
   logic [1:0]       sync_q;
   logic             s_low, s_prev_q, rise, fall;
   logic [CNT_W-1:0] cnt_q;
   logic             rst_len, bit_val, fall_bit;
   logic [7:0]       byte_w;

   logic [2:0]       state_q, state_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [2:0]       bitcnt_q, bitcnt_d;
   logic [6:0]       addr_q, addr_d;
   logic             slot_q, slot_d;
   logic             pull_q, pull_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             mcu_in_q;
   logic             wr_valid_q, wr_valid_d;
   logic [6:0]       wr_addr_q, wr_addr_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic             rd_req_q, rd_req_d;
   logic [6:0]       rd_addr_q, rd_addr_d;

   assign mcu_low = ~mcu_oe_n & ~mcu_out;
   assign s_low   = sync_q[1];
   assign rise    = s_low & ~s_prev_q;
   assign fall    = ~s_low & s_prev_q;
   assign rst_len = (cnt_q >= RST_LIM);
   assign bit_val = (cnt_q < BIT_LIM);
   assign byte_w  = {bit_val, shreg_q[7:1]};

`ifdef SWR_PRESENCE_EN
   // A low that began during the presence pulse is never decoded as a bit.
   logic ign_q;
   always_ff @(posedge ppm_clk or posedge rst) begin
      if (rst)       ign_q <= 1'b0;
      else if (rise) ign_q <= (state_q == ST_PRES);
   end
   assign fall_bit = fall & ~rst_len & ~ign_q;
`else
   assign fall_bit = fall & ~rst_len;
`endif

   always_ff @(posedge ppm_clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         s_prev_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], mcu_low};
         s_prev_q <= s_low;
         if (rise)
            cnt_q <= CNT_W'(1);
         else if (s_low && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bitcnt_d   = bitcnt_q;
      addr_d     = addr_q;
      slot_d     = slot_q;
      pull_d     = pull_q;
      timer_d    = timer_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rd_req_d   = 1'b0;
      rd_addr_d  = rd_addr_q;

      if (fall && rst_len) begin
         pull_d   = 1'b0;
         bitcnt_d = '0;
         slot_d   = 1'b0;
`ifdef SWR_PRESENCE_EN
         timer_d  = '0;
         state_d  = ST_PRES;
`else
         state_d  = ST_CMD;
`endif
      end else begin
         case (state_q)
            ST_CMD: begin
               if (fall_bit) begin
                  shreg_d  = byte_w;
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     addr_d = byte_w[6:0];
                     if (byte_w[7]) begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = byte_w[6:0];
                        state_d   = ST_RLOAD;
                     end else begin
                        state_d   = ST_WDATA;
                     end
                  end
               end
            end
            ST_WDATA: begin
               if (fall_bit) begin
                  shreg_d  = byte_w;
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     wr_valid_d = 1'b1;
                     wr_addr_d  = addr_q;
                     wr_data_d  = byte_w;
                     state_d    = ST_IDLE;
                  end
               end
            end
            ST_RLOAD: begin
               shreg_d  = rd_data;
               bitcnt_d = '0;
               slot_d   = 1'b0;
               state_d  = ST_RDATA;
            end
            ST_RDATA: begin
               if (pull_q) begin
                  if (timer_q == '0) pull_d  = 1'b0;
                  else               timer_d = timer_q - CNT_W'(1);
               end
               // Slot ends once both the MCU and our own hold have released the line.
               if (rise) begin
                  slot_d = 1'b1;
                  if (!shreg_q[0]) begin
                     pull_d  = 1'b1;
                     timer_d = HOLD_LIM - CNT_W'(1);
                  end
               end else if (slot_q && !s_low && !pull_q) begin
                  slot_d   = 1'b0;
                  shreg_d  = {1'b0, shreg_q[7:1]};
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) state_d = ST_IDLE;
               end
            end
`ifdef SWR_PRESENCE_EN
            ST_PRES: begin
               timer_d = timer_q + CNT_W'(1);
               if (timer_q == PRES_ON) pull_d = 1'b1;
               if (timer_q == PRES_END) begin
                  pull_d  = 1'b0;
                  state_d = ST_CMD;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge ppm_clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bitcnt_q   <= '0;
         addr_q     <= '0;
         slot_q     <= 1'b0;
         pull_q     <= 1'b0;
         timer_q    <= '0;
         mcu_in_q   <= 1'b1;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rd_req_q   <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bitcnt_q   <= bitcnt_d;
         addr_q     <= addr_d;
         slot_q     <= slot_d;
         pull_q     <= pull_d;
         timer_q    <= timer_d;
         mcu_in_q   <= ~(mcu_low | pull_q);
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_req_q   <= rd_req_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   assign mcu_in   = mcu_in_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign rd_req   = rd_req_q;
   assign rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_mcu_gpio_sw_responder.sv
// Directed bench for mcu_gpio_sw_responder: write vectors from a table, plus read, abort,
// threshold and mid-frame reset sequences; presence pulse checked when SWR_PRESENCE_EN is set.
module tb_mcu_gpio_sw_responder;

   localparam int HOLD = 90;

   logic       ppm_clk = 1'b0;
   logic       rst;
   logic       mcu_out, mcu_oe_n;
   logic       mcu_in;
   logic       wr_valid, rd_req;
   logic [6:0] wr_addr, rd_addr;
   logic [7:0] wr_data, rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   int         wr_cnt = 0, rd_cnt = 0;
   logic [6:0] wr_addr_seen = '0, rd_addr_seen = '0;
   logic [7:0] wr_data_seen = '0;

   always #5 ppm_clk = ~ppm_clk;

   mcu_gpio_sw_responder dut (
      .ppm_clk  (ppm_clk),
      .rst      (rst),
      .mcu_out  (mcu_out),
      .mcu_oe_n (mcu_oe_n),
      .mcu_in   (mcu_in),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   // Strobe monitor: counts pulse cycles and captures payload while the strobe is high.
   always @(negedge ppm_clk) begin
      if (wr_valid) begin
         wr_cnt       <= wr_cnt + 1;
         wr_addr_seen <= wr_addr;
         wr_data_seen <= wr_data;
      end
      if (rd_req) begin
         rd_cnt       <= rd_cnt + 1;
         rd_addr_seen <= rd_addr;
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic line_low(input int n);
      @(negedge ppm_clk);
      mcu_oe_n = 1'b0;
      mcu_out  = 1'b0;
      repeat (n) @(negedge ppm_clk);
      mcu_oe_n = 1'b1;
      mcu_out  = 1'b1;
      repeat (12) @(negedge ppm_clk);
   endtask

   task automatic reset_pulse(input int n);
      line_low(n);
`ifdef SWR_PRESENCE_EN
      repeat (150) @(negedge ppm_clk);
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, input int t1, input int t0);
      for (int i = 0; i < 8; i++) line_low(b[i] ? t1 : t0);
   endtask

   // One read slot: MCU drives low for lo cycles; returns cycles mcu_in was seen low.
   task automatic rd_slot(input int lo, output int lowcnt);
      lowcnt = 0;
      @(negedge ppm_clk);
      mcu_oe_n = 1'b0;
      mcu_out  = 1'b0;
      for (int i = 0; i < lo + 110; i++) begin
         @(negedge ppm_clk);
         if (!mcu_in) lowcnt++;
         if (i == lo - 1) begin
            mcu_oe_n = 1'b1;
            mcu_out  = 1'b1;
         end
      end
   endtask

   typedef struct {
      int         t1;
      int         t0;
      logic [7:0] cmd;
      logic [7:0] dat;
      logic [6:0] exp_addr;
      logic [7:0] exp_data;
   } wvec_t;

   wvec_t vecs [4];

   initial begin
      int wb, rb, lc;
      logic [7:0] rbyte;

      vecs[0] = '{20, 80,  8'h15, 8'hA5, 7'h15, 8'hA5};
      vecs[1] = '{59, 60,  8'h7F, 8'h00, 7'h7F, 8'h00};
      vecs[2] = '{1,  479, 8'h2A, 8'hFF, 7'h2A, 8'hFF};
      vecs[3] = '{5,  200, 8'h00, 8'h81, 7'h00, 8'h81};

      rst      = 1'b1;
      mcu_oe_n = 1'b1;
      mcu_out  = 1'b1;
      rd_data  = 8'h5A;
      repeat (4) @(negedge ppm_clk);
      check("reset mcu_in",   int'(mcu_in),   1);
      check("reset wr_valid", int'(wr_valid), 0);
      check("reset rd_req",   int'(rd_req),   0);
      check("reset wr_addr",  int'(wr_addr),  0);
      check("reset wr_data",  int'(wr_data),  0);
      check("reset rd_addr",  int'(rd_addr),  0);
      rst = 1'b0;
      repeat (4) @(negedge ppm_clk);

      for (int v = 0; v < 4; v++) begin
         wb = wr_cnt;
         rb = rd_cnt;
         reset_pulse(500);
         send_byte(vecs[v].cmd, vecs[v].t1, vecs[v].t0);
         send_byte(vecs[v].dat, vecs[v].t1, vecs[v].t0);
         check($sformatf("vec%0d wr_valid pulses", v), wr_cnt - wb, 1);
         check($sformatf("vec%0d wr_addr", v), int'(wr_addr_seen), int'(vecs[v].exp_addr));
         check($sformatf("vec%0d wr_data", v), int'(wr_data_seen), int'(vecs[v].exp_data));
         check($sformatf("vec%0d rd_req pulses", v), rd_cnt - rb, 0);
      end

      // Read of addr 0x03 returning 0x5A with 5-cycle MCU slots.
      wb = wr_cnt;
      rb = rd_cnt;
      rbyte = 8'h5A;
      reset_pulse(500);
      send_byte(8'h83, 20, 80);
      check("read rd_req pulses", rd_cnt - rb, 1);
      check("read rd_addr", int'(rd_addr_seen), 3);
      for (int s = 0; s < 8; s++) begin
         rd_slot(5, lc);
         check($sformatf("read slot%0d low cycles", s), lc, rbyte[s] ? 5 : HOLD + 3);
      end
      check("read wr_valid pulses", wr_cnt - wb, 0);

      // Abort: partial command, then a long reset-length low, then a full write.
      wb = wr_cnt;
      rb = rd_cnt;
      reset_pulse(500);
      for (int i = 0; i < 4; i++) line_low(80);
      reset_pulse(600);
      send_byte(8'h01, 20, 80);
      send_byte(8'h3C, 20, 80);
      check("abort wr_valid pulses", wr_cnt - wb, 1);
      check("abort wr_addr", int'(wr_addr_seen), 1);
      check("abort wr_data", int'(wr_data_seen), 8'h3C);
      check("abort rd_req pulses", rd_cnt - rb, 0);

      // Threshold: 479 in IDLE must not open a frame; 480 must.
      wb = wr_cnt;
      reset_pulse(479);
      send_byte(8'h05, 20, 80);
      send_byte(8'h66, 20, 80);
      check("thr479 wr_valid pulses", wr_cnt - wb, 0);
      reset_pulse(480);
      send_byte(8'h05, 20, 80);
      send_byte(8'h66, 20, 80);
      check("thr480 wr_valid pulses", wr_cnt - wb, 1);
      check("thr480 wr_addr", int'(wr_addr_seen), 5);
      check("thr480 wr_data", int'(wr_data_seen), 8'h66);

      // rst while the responder holds the line in a 0 read slot.
      reset_pulse(500);
      send_byte(8'h83, 20, 80);
      @(negedge ppm_clk);
      mcu_oe_n = 1'b0;
      mcu_out  = 1'b0;
      repeat (5) @(negedge ppm_clk);
      mcu_oe_n = 1'b1;
      mcu_out  = 1'b1;
      repeat (20) @(negedge ppm_clk);
      check("rst pre: responder pulling", int'(mcu_in), 0);
      rst = 1'b1;
      @(negedge ppm_clk);
      check("rst mcu_in released", int'(mcu_in), 1);
      repeat (2) @(negedge ppm_clk);
      rst = 1'b0;
      wb = wr_cnt;
      rb = rd_cnt;
      rd_slot(5, lc);
      check("post-rst slot low cycles", lc, 5);
      send_byte(8'h83, 20, 80);
      send_byte(8'h15, 20, 80);
      send_byte(8'hA5, 20, 80);
      check("post-rst wr_valid pulses", wr_cnt - wb, 0);
      check("post-rst rd_req pulses", rd_cnt - rb, 0);

`ifdef SWR_PRESENCE_EN
      begin
         int dly, dur;
         dly = 0;
         dur = 0;
         @(negedge ppm_clk);
         mcu_oe_n = 1'b0;
         mcu_out  = 1'b0;
         repeat (500) @(negedge ppm_clk);
         mcu_oe_n = 1'b1;
         mcu_out  = 1'b1;
         @(negedge ppm_clk);
         while (mcu_in && dly < 200) begin
            @(negedge ppm_clk);
            dly++;
         end
         check("presence delay in range", int'(dly >= 15 && dly <= 20), 1);
         while (!mcu_in && dur < 300) begin
            @(negedge ppm_clk);
            dur++;
         end
         check("presence low cycles", dur, 120);
         repeat (10) @(negedge ppm_clk);
         wb = wr_cnt;
         send_byte(8'h22, 20, 80);
         send_byte(8'h44, 20, 80);
         check("presence wr_valid pulses", wr_cnt - wb, 1);
         check("presence wr_addr", int'(wr_addr_seen), 8'h22);
         check("presence wr_data", int'(wr_data_seen), 8'h44);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
